uart_rx: RTL
============

# uart_rx

Serial-to-parallel UART receiver: the stage directly downstream of `uart_tx`. It oversamples the `rx` line with the same bit timing and packet format, and reassembles `NUM_WORDS` consecutive words into one `W_OUT`-bit beat. That beat goes out on a valid/ready stream interface, with one-cycle pulses flagging framing errors and overflow.

## Interface
- `CLOCKS_PER_PULSE`, 4: clock cycles per UART bit; even, ≥ 4.
- `BITS_PER_WORD`, 8: data bits per serial word, sent LSB first.
- `W_OUT`, 16: output beat width; must be a multiple of `BITS_PER_WORD`.
- `NUM_END_BITS`, 4: high bits after the data bits (stop bits plus padding); packet = 1 start + `BITS_PER_WORD` + `NUM_END_BITS`.
- `clk` in 1: single clock domain.
- `rst` in 1: reset, asynchronous and active-high.
- `rx` in 1: serial line, asynchronous to `clk`, idles high.
- `m_data` out `W_OUT`: received beat; word *k* (k-th received) occupies bits [k·`BITS_PER_WORD` +: `BITS_PER_WORD`].
- `m_valid` out 1: beat available.
- `m_ready` in 1: downstream accepts the beat.
- `frame_err` out 1: one-cycle pulse on a bad start or end bit.
- `overflow` out 1: one-cycle pulse when a completed beat is dropped.

## Operation
- **Synchronizer:** `rx` passes through a 2-flop synchronizer (flops reset to 1) giving `rx_s`. An edge register gives `rx_s_d`.
- **State: IDLE.** On falling edge (`rx_s_d`=1, `rx_s`=0) go to START and clear the cycle counter.
- **State: START.** After `CLOCKS_PER_PULSE/2` cycles, sample `rx_s`:
  - 0 → DATA, bit counter = 0.
  - 1 → glitch: back to IDLE. No error, word counter unchanged.
- **State: DATA.** Every `CLOCKS_PER_PULSE` cycles (mid-bit), shift `rx_s` into the word shift register, LSB first. After `BITS_PER_WORD` samples → END.
- **State: END.** Every `CLOCKS_PER_PULSE` cycles, sample `rx_s`:
  - All `NUM_END_BITS` samples = 1 → write the word into the assembly register at slot = word counter, increment the word counter, go to IDLE.
  - Any sample = 0 → pulse `frame_err`, discard the partial beat (word counter = 0), go to IDLE immediately.
- **Beat completion.** When the word counter reaches `NUM_WORDS` (after the last word's final end-bit sample), the beat completes and the word counter wraps to 0:
  - If `m_valid`=0, or `m_valid`=1 with `m_ready`=1 in that same cycle: load `m_data` from the assembly register; `m_valid`=1.
  - If `m_valid`=1 and `m_ready`=0: keep `m_data`, drop the new beat, pulse `overflow`.
- **Handshake.** `m_valid`/`m_data` hold stable until a cycle with `m_valid && m_ready`. `m_valid` deasserts the next cycle unless a new beat loads in that same cycle.
- **Reset.** Asserting `rst` mid-frame aborts at once:
  - All state goes to IDLE; all counters 0.
  - Outputs: `m_data`=0, `m_valid`=0, `frame_err`=0, `overflow`=0.

## Timing
- Start-edge detection lags the `rx` line by 2 cycles (synchronizer) plus 1 cycle (edge register).
- Sample points fall at the start edge + `CLOCKS_PER_PULSE/2` + n·`CLOCKS_PER_PULSE`, for n = 0 (start bit) .. `BITS_PER_WORD` + `NUM_END_BITS`.
- `m_valid` rises one cycle after the final end-bit sample of word `NUM_WORDS`-1.
- After the final sample the FSM is in IDLE while the line is still high. A start bit immediately following the previous packet is therefore detected.
- `frame_err` and `overflow` are each exactly one cycle wide. They can coincide only with a beat load from a different event; `frame_err` and beat completion are mutually exclusive.

## Structure
- **Package `uart_pkg`:** the state typedef (`IDLE`, `START`, `DATA`, `END`) and the derived constants `NUM_WORDS` = `W_OUT`/`BITS_PER_WORD` and `PACKET_SIZE`. Shared with `uart_tx`.
- **Counter widths:** `$clog2` of the respective maxima.
- **Sub-module `sync_2ff`:** the reset-to-1 two-flop synchronizer. It is reusable elsewhere.

## Test plan
All scenarios use defaults: `CLOCKS_PER_PULSE`=4, 8-bit words, `W_OUT`=16, 4 end bits.

- **Single beat:** send bytes 0xA5 then 0x3C, `m_ready`=1 → one `m_valid` pulse with `m_data`=16'h3CA5, `frame_err`=`overflow`=0.
- **Loopback:** `uart_tx` → `uart_rx`, 10 random 16-bit beats, random gaps of 1–20 cycles → every `m_data` equals the sent `s_data`, in order.
- **Framing error:** send 0x11, then 0x22 with the 2nd end bit forced low → `frame_err` pulses once. Then send 0x33, 0x44 → `m_data`=16'h4433 (0x11 discarded).
- **Backpressure/overflow:** hold `m_ready`=0 and send two beats, 16'h0102 then 16'h0304 → `m_data` stays 16'h0102, `overflow` pulses once at the second completion. Raising `m_ready` → one accept, then `m_valid`=0.
- **Glitch:** drive `rx` low for 1 cycle only → no START→DATA transition, no outputs change, word counter stays 0.
- **Reset mid-frame:** assert `rst` during the 3rd data bit of word 0 → all outputs 0 immediately. After release, a clean beat 16'hBEEF is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and defaults for uart_tx / uart_rx.
// Module parameters override the defaults; derived sizes come from the helper functions.
package uart_pkg;

  localparam int DFLT_CLOCKS_PER_PULSE = 4;
  localparam int DFLT_BITS_PER_WORD    = 8;
  localparam int DFLT_W_OUT            = 16;
  localparam int DFLT_NUM_END_BITS     = 4;

  localparam int NUM_WORDS   = DFLT_W_OUT / DFLT_BITS_PER_WORD;
  localparam int PACKET_SIZE = 1 + DFLT_BITS_PER_WORD + DFLT_NUM_END_BITS;

  typedef enum logic [1:0] {IDLE, START, DATA, END} uart_state_e;

  // Per-cycle datapath actions decoded from the receive FSM.
  typedef struct packed {
    logic cyc_clr;
    logic bit_clr;
    logic bit_inc;
    logic shift;
    logic end_bad;
    logic word_done;
  } rx_ctl_t;

  function automatic int num_words(input int w_out, input int bits_per_word);
    return w_out / bits_per_word;
  endfunction

  function automatic int packet_size(input int bits_per_word, input int num_end_bits);
    return 1 + bits_per_word + num_end_bits;
  endfunction

  // Width of a counter running 0..max-1, never narrower than one bit.
  function automatic int cnt_w(input int max);
    return (max > 1) ? $clog2(max) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an idle-high asynchronous line; both flops reset to 1
// so a reset never looks like a falling edge downstream.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: assembles NUM_WORDS serial words into one W_OUT-bit
// beat on a valid/ready stream, with one-cycle frame_err / overflow pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = DFLT_CLOCKS_PER_PULSE,
  parameter int BITS_PER_WORD    = DFLT_BITS_PER_WORD,
  parameter int W_OUT            = DFLT_W_OUT,
  parameter int NUM_END_BITS     = DFLT_NUM_END_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  output logic [W_OUT-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             frame_err,
  output logic             overflow
);

  localparam int NWORDS = num_words(W_OUT, BITS_PER_WORD);
  localparam int CYC_W  = cnt_w(CLOCKS_PER_PULSE);
  localparam int BIT_W  = cnt_w((BITS_PER_WORD > NUM_END_BITS) ? BITS_PER_WORD : NUM_END_BITS);
  localparam int WRD_W  = cnt_w(NWORDS);

  localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(CLOCKS_PER_PULSE - 1);
  localparam logic [CYC_W-1:0] CYC_HALF  = CYC_W'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(BITS_PER_WORD - 1);
  localparam logic [BIT_W-1:0] END_LAST  = BIT_W'(NUM_END_BITS - 1);
  localparam logic [WRD_W-1:0] WRD_LAST  = WRD_W'(NWORDS - 1);

  if (CLOCKS_PER_PULSE < 4 || (CLOCKS_PER_PULSE % 2) != 0) begin : g_bad_cpp
    $error("uart_rx: CLOCKS_PER_PULSE must be even and >= 4");
  end
  if (BITS_PER_WORD < 2 || (W_OUT % BITS_PER_WORD) != 0) begin : g_bad_w
    $error("uart_rx: W_OUT must be a multiple of BITS_PER_WORD (>= 2)");
  end
  if (NUM_END_BITS < 1) begin : g_bad_end
    $error("uart_rx: NUM_END_BITS must be >= 1");
  end

  logic                     rx_s, rx_s_d;
  uart_state_e              state, state_nxt;
  rx_ctl_t                  ctl;
  logic [CYC_W-1:0]         cyc_cnt;
  logic [BIT_W-1:0]         bit_cnt;
  logic [WRD_W-1:0]         wrd_cnt;
  logic [BITS_PER_WORD-1:0] shreg;
  logic [W_OUT-1:0]         asm_q, asm_nxt;
  logic                     fall, tick, half, beat_done;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_s_d <= 1'b1;
    else     rx_s_d <= rx_s;
  end

  assign fall = rx_s_d & ~rx_s;
  assign tick = (cyc_cnt == CYC_LAST);
  assign half = (cyc_cnt == CYC_HALF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fall) state_nxt = START;
      // A start bit that is high again at mid-bit was a glitch.
      START:   if (half) state_nxt = rx_s ? IDLE : DATA;
      DATA:    if (tick && bit_cnt == DATA_LAST) state_nxt = END;
      END:     if (tick && (!rx_s || bit_cnt == END_LAST)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ctl = '0;
    case (state)
      IDLE: begin
        ctl.cyc_clr = 1'b1;
        ctl.bit_clr = 1'b1;
      end
      START: if (half) begin
        ctl.cyc_clr = 1'b1;
        ctl.bit_clr = 1'b1;
      end
      DATA: if (tick) begin
        ctl.cyc_clr = 1'b1;
        ctl.shift   = 1'b1;
        ctl.bit_clr = (bit_cnt == DATA_LAST);
        ctl.bit_inc = (bit_cnt != DATA_LAST);
      end
      END: if (tick) begin
        ctl.cyc_clr   = 1'b1;
        ctl.bit_inc   = 1'b1;
        ctl.end_bad   = ~rx_s;
        ctl.word_done = rx_s && (bit_cnt == END_LAST);
      end
      default: ctl = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      cyc_cnt <= ctl.cyc_clr ? '0 : cyc_cnt + 1'b1;
      if (ctl.bit_clr)      bit_cnt <= '0;
      else if (ctl.bit_inc) bit_cnt <= bit_cnt + 1'b1;
      if (ctl.shift) shreg <= {rx_s, shreg[BITS_PER_WORD-1:1]};
    end
  end

  // Assembly register with the current word dropped into its slot.
  always_comb begin
    asm_nxt = asm_q;
    for (int k = 0; k < NWORDS; k++) begin
      if (wrd_cnt == WRD_W'(k)) asm_nxt[k*BITS_PER_WORD +: BITS_PER_WORD] = shreg;
    end
  end

  assign beat_done = ctl.word_done && (wrd_cnt == WRD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrd_cnt <= '0;
      asm_q   <= '0;
    end else if (ctl.end_bad) begin
      wrd_cnt <= '0;
    end else if (ctl.word_done) begin
      asm_q   <= asm_nxt;
      wrd_cnt <= (wrd_cnt == WRD_LAST) ? '0 : wrd_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data    <= '0;
      m_valid   <= 1'b0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= ctl.end_bad;
      overflow  <= beat_done && m_valid && !m_ready;
      if (beat_done && (!m_valid || m_ready)) begin
        m_data  <= asm_nxt;
        m_valid <= 1'b1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule
